// File: rtl/pulse_delay_multi.sv
// Multi-channel delayed-pulse generator: rising edge on sig_in[i] -> wait D cycles -> pulse W cycles.
// Delay, width and retrigger mode are latched per channel when a trigger is accepted.
module pulse_delay_multi #(
  parameter int CHANNELS    = 4,
  parameter int COUNT_WIDTH = 6
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic [CHANNELS-1:0]    sig_in,
  input  logic [COUNT_WIDTH-1:0] delay_cfg,
  input  logic [COUNT_WIDTH-1:0] width_cfg,
  input  logic                   retrig,
  input  logic                   clear_ovr,
  output logic [CHANNELS-1:0]    sig_out,
  output logic [CHANNELS-1:0]    busy,
  output logic [CHANNELS-1:0]    overrun
);

  typedef enum logic [1:0] {IDLE, DELAY, PULSE} state_t;

  // Last count value of a pulse; a width of 0 behaves as 1.
  function automatic logic [COUNT_WIDTH-1:0] width_last(input logic [COUNT_WIDTH-1:0] w);
    return (w == '0) ? '0 : w - 1'b1;
  endfunction

  logic [CHANNELS-1:0] sig_in_p1;
  logic [CHANNELS-1:0] trig;
  logic [CHANNELS-1:0] drop;

  // Stage p1: previous input sample; resets high so a level held through reset is not an edge.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) sig_in_p1 <= '1;
    else       sig_in_p1 <= sig_in;
  end

  assign trig = sig_in & ~sig_in_p1;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) overrun <= '0;
    else       overrun <= (clear_ovr ? '0 : overrun) | drop;
  end

  for (genvar i = 0; i < CHANNELS; i++) begin : g_ch
    state_t                 state;
    logic [COUNT_WIDTH-1:0] cnt;
    logic [COUNT_WIDTH-1:0] d_lat;
    logic [COUNT_WIDTH-1:0] w_lat;
    logic                   rt_lat;
    logic                   out_r;
    logic                   busy_r;
    logic                   pulse_last;
    logic                   accept;

    assign pulse_last = (state == PULSE) && (cnt == width_last(w_lat));
    assign drop[i]    = trig[i] && !rt_lat &&
                        ((state == DELAY) || ((state == PULSE) && !pulse_last));
    assign accept     = trig[i] && !drop[i];
    assign sig_out[i] = out_r;
    assign busy[i]    = busy_r;

    always_ff @(posedge clk) begin
      if (accept) begin
        d_lat  <= delay_cfg;
        w_lat  <= width_cfg;
        rt_lat <= retrig;
      end
    end

    // Stage p1: channel FSM with registered outputs.
    always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
        state  <= IDLE;
        cnt    <= '0;
        out_r  <= 1'b0;
        busy_r <= 1'b0;
      end else begin
        case (state)
          IDLE: begin
            if (trig[i]) begin
              state  <= DELAY;
              cnt    <= '0;
              busy_r <= 1'b1;
            end
          end
          DELAY: begin
            if (trig[i] && rt_lat) begin
              cnt <= '0;
            end else if (cnt == d_lat) begin
              state <= PULSE;
              cnt   <= '0;
              out_r <= 1'b1;
            end else begin
              cnt <= cnt + 1'b1;
            end
          end
          PULSE: begin
            if (pulse_last) begin
              if (trig[i]) begin
                // The final pulse cycle overlaps the first delay cycle of the new operation.
                if (delay_cfg == '0) begin
                  cnt <= '0;
                end else begin
                  state <= DELAY;
                  cnt   <= {{(COUNT_WIDTH-1){1'b0}}, 1'b1};
                  out_r <= 1'b0;
                end
              end else begin
                state  <= IDLE;
                cnt    <= '0;
                out_r  <= 1'b0;
                busy_r <= 1'b0;
              end
            end else if (trig[i] && rt_lat) begin
              state <= DELAY;
              cnt   <= '0;
              out_r <= 1'b0;
            end else begin
              cnt <= cnt + 1'b1;
            end
          end
          default: begin
            state  <= IDLE;
            cnt    <= '0;
            out_r  <= 1'b0;
            busy_r <= 1'b0;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_pulse_delay_multi.sv
// Directed bench for pulse_delay_multi: per-cycle checks of sig_out, busy and overrun on hand-timed scenarios.
module tb_pulse_delay_multi;
  localparam int CH = 4;
  localparam int CW = 6;
  localparam int NONE = 9999;

  logic          clk = 1'b0;
  logic          reset;
  logic [CH-1:0] sig_in;
  logic [CW-1:0] delay_cfg;
  logic [CW-1:0] width_cfg;
  logic          retrig;
  logic          clear_ovr;
  logic [CH-1:0] sig_out;
  logic [CH-1:0] busy;
  logic [CH-1:0] overrun;

  int checks = 0;
  int failures = 0;

  pulse_delay_multi #(.CHANNELS(CH), .COUNT_WIDTH(CW)) dut (
    .clk       (clk),
    .reset     (reset),
    .sig_in    (sig_in),
    .delay_cfg (delay_cfg),
    .width_cfg (width_cfg),
    .retrig    (retrig),
    .clear_ovr (clear_ovr),
    .sig_out   (sig_out),
    .busy      (busy),
    .overrun   (overrun)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Trigger ch0 at edge 0; optional extra edges at e2/e3 and a clear_ovr at ec (edge indices).
  // Expected: sig_out high in [r1,f1) and [r2,f2), busy high in [0,b_end), overrun set after o_at.
  task automatic trace(input string tag, input int n, input int e2, input int e3, input int ec,
                       input int r1, input int f1, input int r2, input int f2,
                       input int b_end, input int o_at, input bit scramble);
    sig_in[0] = 1'b1;
    step();
    for (int k = 0; k < n; k++) begin
      if (k > 0) step();
      chk({tag, "_out"}, {31'd0, sig_out[0]}, {31'd0, ((k >= r1 && k < f1) || (k >= r2 && k < f2))});
      chk({tag, "_busy"}, {31'd0, busy[0]}, {31'd0, (k < b_end)});
      if (k != o_at) chk({tag, "_ovr"}, {31'd0, overrun[0]}, {31'd0, (k > o_at)});
      sig_in[0] = (k + 1 == e2) || (k + 1 == e3);
      clear_ovr = (k + 1 == ec);
      if (scramble && k == 0) begin
        delay_cfg = 6'd3;
        width_cfg = 6'd9;
      end
    end
    sig_in[0] = 1'b0;
    clear_ovr = 1'b0;
    step();
  endtask

  initial begin
    reset = 1'b1;
    sig_in = '1;
    delay_cfg = '0;
    width_cfg = '0;
    retrig = 1'b0;
    clear_ovr = 1'b0;
    repeat (3) step();
    chk("rst_out", {28'd0, sig_out}, 32'd0);
    chk("rst_busy", {28'd0, busy}, 32'd0);
    chk("rst_ovr", {28'd0, overrun}, 32'd0);

    // Inputs held high across reset release must not trigger.
    reset = 1'b0;
    for (int k = 0; k < 15; k++) begin
      step();
      chk("held_out", {28'd0, sig_out}, 32'd0);
      chk("held_busy", {28'd0, busy}, 32'd0);
    end
    sig_in = '0;
    repeat (2) step();

    delay_cfg = 6'd10; width_cfg = 6'd1; retrig = 1'b0;
    trace("d10w1", 16, NONE, NONE, NONE, 11, 12, NONE, NONE, 12, NONE, 1'b1);

    delay_cfg = 6'd0; width_cfg = 6'd0; retrig = 1'b0;
    trace("d0w0", 5, NONE, NONE, NONE, 1, 2, NONE, NONE, 2, NONE, 1'b0);

    delay_cfg = 6'd10; width_cfg = 6'd3; retrig = 1'b0;
    trace("ovr", 17, 5, 8, 8, 11, 14, NONE, NONE, 14, 5, 1'b0);
    clear_ovr = 1'b1;
    step();
    clear_ovr = 1'b0;
    chk("ovr_clear", {31'd0, overrun[0]}, 32'd0);

    delay_cfg = 6'd10; width_cfg = 6'd3; retrig = 1'b1;
    trace("retrig", 34, 5, 17, NONE, 16, 17, 28, 31, 31, NONE, 1'b0);

    delay_cfg = 6'd4; width_cfg = 6'd2; retrig = 1'b0;
    trace("b2b", 16, 7, NONE, NONE, 5, 7, 11, 13, 13, NONE, 1'b0);

    delay_cfg = 6'd0; width_cfg = 6'd2; retrig = 1'b0;
    trace("b2b_d0", 8, 3, NONE, NONE, 1, 5, NONE, NONE, 5, NONE, 1'b0);

    // ch1 in PULSE with an overrun, ch0 in DELAY, then asynchronous reset between edges.
    delay_cfg = 6'd4; width_cfg = 6'd10; retrig = 1'b0;
    sig_in[1] = 1'b1;
    step();
    sig_in[1] = 1'b0;
    for (int k = 1; k < 10; k++) begin
      step();
      sig_in[0] = (k == 5);
      sig_in[1] = (k == 7);
    end
    chk("pre_busy0", {31'd0, busy[0]}, 32'd1);
    chk("pre_out0", {31'd0, sig_out[0]}, 32'd0);
    chk("pre_out1", {31'd0, sig_out[1]}, 32'd1);
    chk("pre_ovr1", {31'd0, overrun[1]}, 32'd1);
    sig_in = 4'b0011;
    #2 reset = 1'b1;
    #1;
    chk("arst_out", {28'd0, sig_out}, 32'd0);
    chk("arst_busy", {28'd0, busy}, 32'd0);
    chk("arst_ovr", {28'd0, overrun}, 32'd0);
    step();
    sig_in = '0;
    step();
    reset = 1'b0;
    for (int k = 0; k < 20; k++) begin
      step();
      chk("post_out", {28'd0, sig_out}, 32'd0);
      chk("post_busy", {28'd0, busy}, 32'd0);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
